// File: rtl/display_bbox_scaler_if.sv
// Detection stream from YOLO post-processing into the bbox scaler.
// The master drives detection words; the slave returns det_ready.
interface display_bbox_scaler_if;
  logic [63:0] det_data;
  logic        det_valid;
  logic        det_last;
  logic        det_null;
  logic        det_ready;

  modport master (
    output det_data,
    output det_valid,
    output det_last,
    output det_null,
    input  det_ready
  );

  modport slave (
    input  det_data,
    input  det_valid,
    input  det_last,
    input  det_null,
    output det_ready
  );
endinterface

// File: rtl/display_bbox_scaler.sv
// Buffers one frame of model-space boxes and, on vertical blanking, emits exactly
// MAX_BBOX scaled, clipped display boxes (all-ones for unused or degenerate slots).
module display_bbox_scaler #(
  parameter int          MAX_BBOX     = 5,
  parameter int          FRAME_WIDTH  = 1280,
  parameter int          FRAME_HEIGHT = 720,
  parameter logic [15:0] SCALE_X      = 16'h0D55,
  parameter logic [15:0] SCALE_Y      = 16'h0780
) (
  input  logic                   clk,
  input  logic                   rst_n,
  display_bbox_scaler_if.slave   det,
  input  logic                   vblank_pulse,
  output logic [63:0]            bbox_data_out,
  output logic                   bbox_data_out_valid,
  output logic                   bbox_overflow
);

  localparam int              CW        = $clog2(MAX_BBOX + 2);
  localparam logic [CW-1:0]   MAX_CNT   = CW'(MAX_BBOX);
  localparam logic [CW-1:0]   LAST_FCNT = CW'(MAX_BBOX + 1);
  localparam logic [15:0]     X_LIM     = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0]     Y_LIM     = 16'(FRAME_HEIGHT - 1);
  localparam logic [63:0]     NO_BOX    = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PENDING = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          ready_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] fcnt_r;
  logic [63:0]   buffer_r [MAX_BBOX];
  logic          ovf_r;

  logic          xfer_s;
  logic          store_s;
  logic          drop_s;
  logic          issue_s;
  logic          flush_done_s;
  logic [63:0]   rd_s;

  logic          s1_valid_r;
  logic          s1_empty_r;
  logic [31:0]   s1_prod_r [4];

  logic [15:0]   cx0_s;
  logic [15:0]   cy0_s;
  logic [15:0]   cx1_s;
  logic [15:0]   cy1_s;
  logic [63:0]   word_s;

  // Round half-up to integer pixels, then clamp to the last valid pixel.
  function automatic logic [15:0] round_clip(input logic [31:0] prod, input logic [15:0] lim);
    logic [32:0] sum;
    logic [24:0] scaled;
    sum    = {1'b0, prod} + 33'h0_0000_0080;
    scaled = sum[32:8];
    if (scaled > {9'd0, lim}) begin
      round_clip = lim;
    end else begin
      round_clip = scaled[15:0];
    end
  endfunction

  assign det.det_ready       = ready_r;
  assign bbox_overflow       = ovf_r;
  assign xfer_s       = det.det_valid & ready_r;
  assign store_s      = xfer_s & ~det.det_null & (count_r < MAX_CNT);
  assign drop_s       = xfer_s & ~det.det_null & (count_r == MAX_CNT);
  assign issue_s      = (state_r == FLUSH) && (fcnt_r < MAX_CNT);
  assign flush_done_s = (state_r == FLUSH) && (fcnt_r == LAST_FCNT);

  // Next-state decode for the collect / pending / flush sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      COLLECT: begin
        if (xfer_s && (det.det_last || det.det_null)) begin
          state_s = PENDING;
        end else begin
          state_s = COLLECT;
        end
      end
      PENDING: begin
        if (vblank_pulse) begin
          state_s = FLUSH;
        end else begin
          state_s = PENDING;
        end
      end
      FLUSH: begin
        if (flush_done_s) begin
          state_s = COLLECT;
        end else begin
          state_s = FLUSH;
        end
      end
      default: state_s = COLLECT;
    endcase
  end

  // State register; ready is registered from the next state so it tracks COLLECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= COLLECT;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == COLLECT);
    end
  end

  // Box count: saturates at MAX_BBOX, cleared once the flush has drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CW'(0);
    end else if (store_s) begin
      count_r <= count_r + CW'(1);
    end else if (flush_done_s) begin
      count_r <= CW'(0);
    end
  end

  // Raw detection buffer, written in arrival order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_BBOX; i++) begin
        buffer_r[i] <= 64'd0;
      end
    end else begin
      for (int i = 0; i < MAX_BBOX; i++) begin
        if (store_s && (count_r == CW'(i))) begin
          buffer_r[i] <= det.det_data;
        end
      end
    end
  end

  // Drop indication, one cycle after the rejected transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= drop_s;
    end
  end

  // Flush slot counter: issues slots 0..MAX_BBOX-1, then waits for pipeline drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_r <= CW'(0);
    end else if ((state_r == FLUSH) && !flush_done_s) begin
      fcnt_r <= fcnt_r + CW'(1);
    end else begin
      fcnt_r <= CW'(0);
    end
  end

  // Buffer read for the slot being issued.
  always_comb begin
    rd_s = 64'd0;
    for (int i = 0; i < MAX_BBOX; i++) begin
      rd_s = (fcnt_r == CW'(i)) ? buffer_r[i] : rd_s;
    end
  end

  // Pipeline stage 1: per-coordinate Q8.8 multiply and empty-slot flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_empty_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        s1_prod_r[i] <= 32'd0;
      end
    end else begin
      s1_valid_r   <= issue_s;
      s1_empty_r   <= (fcnt_r >= count_r);
      s1_prod_r[0] <= 32'(rd_s[63:48]) * 32'(SCALE_X);
      s1_prod_r[1] <= 32'(rd_s[47:32]) * 32'(SCALE_Y);
      s1_prod_r[2] <= 32'(rd_s[31:16]) * 32'(SCALE_X);
      s1_prod_r[3] <= 32'(rd_s[15:0])  * 32'(SCALE_Y);
    end
  end

  // Pipeline stage 2 logic: round, clip, and replace empty/inverted boxes.
  always_comb begin
    cx0_s = round_clip(s1_prod_r[0], X_LIM);
    cy0_s = round_clip(s1_prod_r[1], Y_LIM);
    cx1_s = round_clip(s1_prod_r[2], X_LIM);
    cy1_s = round_clip(s1_prod_r[3], Y_LIM);
    if (s1_empty_r || (cx0_s > cx1_s) || (cy0_s > cy1_s)) begin
      word_s = NO_BOX;
    end else begin
      word_s = {cx0_s, cy0_s, cx1_s, cy1_s};
    end
  end

  // Output register; data is held at zero between flush words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bbox_data_out       <= 64'd0;
      bbox_data_out_valid <= 1'b0;
    end else begin
      bbox_data_out       <= s1_valid_r ? word_s : 64'd0;
      bbox_data_out_valid <= s1_valid_r;
    end
  end

endmodule
